// File: rtl/apb_slave_pkg.sv
// Shared types and constants for the APB register-bank slave.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package apb_slave_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    typedef enum logic [2:0] {
        DEC_REG,
        DEC_ID,
        DEC_WCNT,
        DEC_RCNT,
        DEC_ERR
    } dec_t;

    localparam logic [11:0] ID_OFS   = 12'h100;
    localparam logic [11:0] WCNT_OFS = 12'h104;
    localparam logic [11:0] RCNT_OFS = 12'h108;

    localparam logic [31:0] ID_VALUE_DEF = 32'h5A5B_0001;

endpackage

// File: rtl/apb_regbank_core.sv
// Register array, transfer counters, address decode and read mux.
// Latency: decode/readmux combinational; state updates on the edge where complete=1.
// Backpressure: none; the caller decides when a transfer completes.
module apb_regbank_core
    import apb_slave_pkg::*;
#(
    parameter int unsigned ADDR_W   = 20,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NREGS    = 8,
    parameter logic [31:0] ID_VALUE = ID_VALUE_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              complete,
    input  logic              write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              err
);

    localparam int unsigned IDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam logic [ADDR_W-1:0] REG_END = ADDR_W'(4 * NREGS);
    localparam logic [ADDR_W-1:0] ID_A    = ADDR_W'(ID_OFS);
    localparam logic [ADDR_W-1:0] WCNT_A  = ADDR_W'(WCNT_OFS);
    localparam logic [ADDR_W-1:0] RCNT_A  = ADDR_W'(RCNT_OFS);

    logic [DATA_W-1:0] regs [NREGS];
    logic [15:0]       wcnt;
    logic [15:0]       rcnt;
    logic [IDX_W-1:0]  idx;
    dec_t              dec;

    assign idx = addr[IDX_W+1:2];

    always_comb begin
        dec = DEC_ERR;
        if (addr[1:0] == 2'b00) begin
            if (addr < REG_END)       dec = DEC_REG;
            else if (addr == ID_A)    dec = DEC_ID;
            else if (addr == WCNT_A)  dec = DEC_WCNT;
            else if (addr == RCNT_A)  dec = DEC_RCNT;
        end
    end

    // Only the general registers accept writes; everything else is read-only.
    assign err = (dec == DEC_ERR) || (write && (dec != DEC_REG));

    always_comb begin
        rdata = '0;
        case (dec)
            DEC_REG:  rdata = regs[idx];
            DEC_ID:   rdata = DATA_W'(ID_VALUE);
            DEC_WCNT: rdata = DATA_W'(wcnt);
            DEC_RCNT: rdata = DATA_W'(rcnt);
            default:  rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NREGS); i++) regs[i] <= '0;
            wcnt <= '0;
            rcnt <= '0;
        end else if (complete && !err) begin
            if (write) begin
                regs[idx] <= wdata;
                wcnt      <= wcnt + 16'd1;
            end else begin
                rcnt      <= rcnt + 16'd1;
            end
        end
    end

endmodule

// File: rtl/apb_slave_regbank.sv
// APB slave with RW registers, ID and transfer counters, configurable wait states.
// Latency: completes WAIT_STATES+1 edges after the SETUP edge.
// Backpressure: holds PREADY low for WAIT_STATES ACCESS cycles; outputs held until next completion.
module apb_slave_regbank
    import apb_slave_pkg::*;
#(
    parameter int unsigned ADDR_W      = 20,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned NREGS       = 8,
    parameter int unsigned WAIT_STATES = 0,
    parameter logic [31:0] ID_VALUE    = ID_VALUE_DEF
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [DATA_W-1:0] PWDATA,
    output logic [DATA_W-1:0] PRDATA,
    output logic              PREADY,
    output logic              PSLVERR
);

    state_t            state, state_nxt;
    logic [3:0]        wcnt, wcnt_nxt;
    logic              latch_en;
    logic              complete;
    logic              a_write;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic [DATA_W-1:0] core_rdata;
    logic              core_err;

    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        latch_en  = 1'b0;
        complete  = 1'b0;
        // A SETUP phase restarts the transfer from any state.
        if (PSEL && !PENABLE) begin
            state_nxt = ACCESS;
            wcnt_nxt  = 4'(WAIT_STATES);
            latch_en  = 1'b1;
        end else begin
            case (state)
                ACCESS: begin
                    if (!PSEL) begin
                        state_nxt = IDLE;
                    end else if (wcnt != 4'd0) begin
                        wcnt_nxt = wcnt - 4'd1;
                    end else if (PENABLE) begin
                        complete  = 1'b1;
                        state_nxt = DONE;
                    end
                end
                DONE: begin
                    if (!PSEL) state_nxt = IDLE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state   <= IDLE;
            wcnt    <= '0;
            a_write <= 1'b0;
            a_addr  <= '0;
            a_wdata <= '0;
            PREADY  <= 1'b0;
            PSLVERR <= 1'b0;
            PRDATA  <= '0;
        end else begin
            state  <= state_nxt;
            wcnt   <= wcnt_nxt;
            // Registered copy of the (state==ACCESS && wcnt==0) condition.
            PREADY <= (state_nxt == ACCESS) && (wcnt_nxt == 4'd0);
            if (latch_en) begin
                a_write <= PWRITE;
                a_addr  <= PADDR;
                a_wdata <= PWDATA;
            end
            if (complete) begin
                PSLVERR <= core_err;
                if (core_err)      PRDATA <= '0;
                else if (!a_write) PRDATA <= core_rdata;
            end
        end
    end

    apb_regbank_core #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .NREGS    (NREGS),
        .ID_VALUE (ID_VALUE)
    ) u_core (
        .clk      (PCLK),
        .rst      (PRESET),
        .complete (complete),
        .write    (a_write),
        .addr     (a_addr),
        .wdata    (a_wdata),
        .rdata    (core_rdata),
        .err      (core_err)
    );

endmodule

// File: tb/tb_apb_slave_regbank.sv
// Randomized bench for apb_slave_regbank against an address-map level model.
module tb_apb_slave_regbank;

    localparam int AW = 20;
    localparam int DW = 32;
    localparam int NR = 8;
    localparam int WS = 2;
    localparam logic [31:0] IDV = 32'h5A5B_0001;

    logic          PCLK = 1'b0;
    logic          PRESET, PSEL, PENABLE, PWRITE;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA, PRDATA;
    logic          PREADY, PSLVERR;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] m_reg [NR];
    int          m_wcnt, m_rcnt;
    logic [31:0] m_prdata;
    logic        m_err;

    apb_slave_regbank #(
        .ADDR_W(AW), .DATA_W(DW), .NREGS(NR), .WAIT_STATES(WS), .ID_VALUE(IDV)
    ) dut (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        for (int i = 0; i < NR; i++) m_reg[i] = '0;
        m_wcnt = 0; m_rcnt = 0; m_prdata = '0; m_err = 1'b0;
    endtask

    // Abstract model: classify the address, then apply the transfer rules.
    task automatic model_xfer(input logic w, input int unsigned a, input logic [31:0] d);
        int kind;
        logic [31:0] val;
        if (a % 4 != 0)          kind = 4;
        else if (a < 4 * NR)     kind = 0;
        else if (a == 256)       kind = 1;
        else if (a == 260)       kind = 2;
        else if (a == 264)       kind = 3;
        else                     kind = 4;
        if (kind == 4 || (w && kind != 0)) begin
            m_err = 1'b1;
            m_prdata = '0;
        end else begin
            m_err = 1'b0;
            if (w) begin
                m_reg[a / 4] = d;
                m_wcnt = (m_wcnt + 1) % 65536;
            end else begin
                case (kind)
                    0:       val = m_reg[a / 4];
                    1:       val = IDV;
                    2:       val = 32'(m_wcnt);
                    default: val = 32'(m_rcnt);
                endcase
                m_prdata = val;
                m_rcnt = (m_rcnt + 1) % 65536;
            end
        end
    endtask

    // One APB transfer; address/data are scrambled during wait states.
    task automatic apb_xfer(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic hold, output logic [DW-1:0] rd, output logic er,
                            output int waits, output logic rdy_after,
                            output logic [DW-1:0] rd_late, output logic er_late);
        int cyc;
        @(negedge PCLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = w; PADDR = a; PWDATA = d;
        @(negedge PCLK);
        PENABLE = 1'b1;
        cyc = 0;
        while (PREADY !== 1'b1 && cyc < 40) begin
            PADDR = AW'($urandom); PWDATA = $urandom;
            @(negedge PCLK);
            cyc++;
        end
        waits = cyc;
        n_tests++;
        if (cyc >= 40) begin
            n_fail++;
            $display("FAIL ready_timeout: PREADY=%b after %0d cycles, required 1", PREADY, cyc);
        end
        @(negedge PCLK);
        rd = PRDATA; er = PSLVERR; rdy_after = PREADY;
        if (!hold) begin PSEL = 1'b0; PENABLE = 1'b0; end
        @(negedge PCLK);
        rd_late = PRDATA; er_late = PSLVERR;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic test_reset();
        model_reset();
        PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
        repeat (3) @(negedge PCLK);
        n_tests += 3;
        if (PREADY !== 1'b0)  begin n_fail++; $display("FAIL reset_pready: got %b, required 0", PREADY); end
        if (PSLVERR !== 1'b0) begin n_fail++; $display("FAIL reset_pslverr: got %b, required 0", PSLVERR); end
        if (PRDATA !== '0)    begin n_fail++; $display("FAIL reset_prdata: got %h, required 0", PRDATA); end
        PRESET = 1'b0;
    endtask

    task automatic test_id_rcnt();
        logic [DW-1:0] rd, rl; logic er, el, ra; int wt;
        model_xfer(1'b0, 32'h100, '0);
        apb_xfer(1'b0, 20'h00100, '0, 1'b0, rd, er, wt, ra, rl, el);
        n_tests += 2;
        if (rd !== 32'h5A5B0001) begin n_fail++; $display("FAIL id_read: got %h, required 5a5b0001", rd); end
        if (er !== 1'b0) begin n_fail++; $display("FAIL id_err: got %b, required 0", er); end
        model_xfer(1'b0, 32'h108, '0);
        apb_xfer(1'b0, 20'h00108, '0, 1'b0, rd, er, wt, ra, rl, el);
        n_tests++;
        if (rd !== 32'h1) begin n_fail++; $display("FAIL rcnt_read: got %h, required 00000001", rd); end
    endtask

    task automatic test_write_read();
        logic [DW-1:0] rd, rl; logic er, el, ra; int wt;
        model_xfer(1'b1, 32'h4, 32'hDEADBEEF);
        apb_xfer(1'b1, 20'h00004, 32'hDEADBEEF, 1'b0, rd, er, wt, ra, rl, el);
        n_tests += 2;
        if (er !== 1'b0) begin n_fail++; $display("FAIL wr_err: got %b, required 0", er); end
        if (rd !== m_prdata) begin n_fail++; $display("FAIL wr_prdata_hold: got %h, required %h", rd, m_prdata); end
        model_xfer(1'b0, 32'h4, '0);
        apb_xfer(1'b0, 20'h00004, '0, 1'b0, rd, er, wt, ra, rl, el);
        n_tests++;
        if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL reg1_read: got %h, required deadbeef", rd); end
        model_xfer(1'b0, 32'h104, '0);
        apb_xfer(1'b0, 20'h00104, '0, 1'b0, rd, er, wt, ra, rl, el);
        n_tests++;
        if (rd !== 32'h1) begin n_fail++; $display("FAIL wcnt_read: got %h, required 00000001", rd); end
        for (int i = 0; i < NR; i++) begin
            if (i != 1) begin
                model_xfer(1'b0, 32'(4 * i), '0);
                apb_xfer(1'b0, AW'(4 * i), '0, 1'b0, rd, er, wt, ra, rl, el);
                n_tests++;
                if (rd !== 32'h0) begin n_fail++; $display("FAIL other_reg_%0d: got %h, required 0", i, rd); end
            end
        end
    endtask

    task automatic test_wait_states();
        logic [DW-1:0] rd, rl, d; logic er, el, ra; int wt;
        d = $urandom;
        model_xfer(1'b1, 32'h0, d);
        apb_xfer(1'b1, 20'h00000, d, 1'b0, rd, er, wt, ra, rl, el);
        n_tests += 2;
        if (wt !== WS) begin n_fail++; $display("FAIL wait_cycles: got %0d, required %0d", wt, WS); end
        if (ra !== 1'b0) begin n_fail++; $display("FAIL pready_after_done: got %b, required 0", ra); end
        model_xfer(1'b0, 32'h0, '0);
        apb_xfer(1'b0, 20'h00000, '0, 1'b0, rd, er, wt, ra, rl, el);
        n_tests++;
        if (rd !== d) begin n_fail++; $display("FAIL ws_readback: got %h, required %h", rd, d); end
    endtask

    task automatic test_errors();
        logic [DW-1:0] rd, rl; logic er, el, ra; int wt;
        logic [AW-1:0] addrs [3];
        logic          wrs   [3];
        addrs[0] = 20'h00100; wrs[0] = 1'b1;
        addrs[1] = 20'h00006; wrs[1] = 1'b1;
        addrs[2] = 20'h00200; wrs[2] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            model_xfer(wrs[k], 32'(addrs[k]), 32'h1234_5678);
            apb_xfer(wrs[k], addrs[k], 32'h1234_5678, 1'b0, rd, er, wt, ra, rl, el);
            n_tests += 3;
            if (er !== 1'b1) begin n_fail++; $display("FAIL err_%0d_pslverr: got %b, required 1", k, er); end
            if (el !== 1'b1) begin n_fail++; $display("FAIL err_%0d_held: got %b, required 1", k, el); end
            if (rd !== m_prdata) begin n_fail++; $display("FAIL err_%0d_prdata: got %h, required %h", k, rd, m_prdata); end
        end
        model_xfer(1'b0, 32'h100, '0);
        apb_xfer(1'b0, 20'h00100, '0, 1'b0, rd, er, wt, ra, rl, el);
        n_tests += 2;
        if (rd !== IDV) begin n_fail++; $display("FAIL id_after_err: got %h, required %h", rd, IDV); end
        if (er !== 1'b0) begin n_fail++; $display("FAIL err_cleared: got %b, required 0", er); end
        model_xfer(1'b0, 32'h104, '0);
        apb_xfer(1'b0, 20'h00104, '0, 1'b0, rd, er, wt, ra, rl, el);
        n_tests++;
        if (rd !== 32'(m_wcnt)) begin n_fail++; $display("FAIL wcnt_after_err: got %h, required %h", rd, 32'(m_wcnt)); end
    endtask

    task automatic test_extra_hold();
        logic [DW-1:0] rd, rl, d; logic er, el, ra; int wt;
        d = $urandom;
        model_xfer(1'b1, 32'hC, d);
        apb_xfer(1'b1, 20'h0000C, d, 1'b1, rd, er, wt, ra, rl, el);
        model_xfer(1'b0, 32'h104, '0);
        apb_xfer(1'b0, 20'h00104, '0, 1'b1, rd, er, wt, ra, rl, el);
        n_tests += 2;
        if (rd !== 32'(m_wcnt)) begin n_fail++; $display("FAIL hold_single_write: got %h, required %h", rd, 32'(m_wcnt)); end
        if (rl !== rd) begin n_fail++; $display("FAIL hold_prdata_stable: got %h, required %h", rl, rd); end
        model_xfer(1'b0, 32'hC, '0);
        apb_xfer(1'b0, 20'h0000C, '0, 1'b0, rd, er, wt, ra, rl, el);
        n_tests++;
        if (rd !== d) begin n_fail++; $display("FAIL hold_readback: got %h, required %h", rd, d); end
    endtask

    task automatic test_idle_penable();
        logic [DW-1:0] rd, rl; logic er, el, ra; int wt;
        @(negedge PCLK);
        PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = 20'h00010; PWDATA = 32'hFFFF_FFFF;
        repeat (4) begin
            @(negedge PCLK);
            n_tests++;
            if (PREADY !== 1'b0) begin n_fail++; $display("FAIL idle_penable_pready: got %b, required 0", PREADY); end
        end
        PSEL = 1'b0; PENABLE = 1'b0;
        model_xfer(1'b0, 32'h10, '0);
        apb_xfer(1'b0, 20'h00010, '0, 1'b0, rd, er, wt, ra, rl, el);
        n_tests++;
        if (rd !== m_prdata) begin n_fail++; $display("FAIL idle_penable_reg: got %h, required %h", rd, m_prdata); end
    endtask

    task automatic test_random();
        logic [DW-1:0] rd, rl, d; logic er, el, ra, w; int wt, kind;
        int unsigned a;
        for (int n = 0; n < 60; n++) begin
            kind = $urandom_range(0, 6);
            case (kind)
                0, 1:    a = 4 * $urandom_range(0, NR - 1);
                2:       a = 32'h100 + 4 * $urandom_range(0, 2);
                3:       a = 4 * $urandom_range(0, NR - 1) + $urandom_range(1, 3);
                4:       a = 4 * $urandom_range(NR, 63);
                5:       a = 32'h10C + 4 * $urandom_range(0, 1000);
                default: a = $urandom_range(0, (1 << AW) - 1);
            endcase
            w = 1'($urandom_range(0, 1));
            d = $urandom;
            model_xfer(w, a, d);
            apb_xfer(w, AW'(a), d, 1'($urandom_range(0, 1)), rd, er, wt, ra, rl, el);
            n_tests += 3;
            if (rd !== m_prdata) begin n_fail++; $display("FAIL rand_%0d_prdata a=%h w=%b: got %h, required %h", n, a, w, rd, m_prdata); end
            if (er !== m_err) begin n_fail++; $display("FAIL rand_%0d_pslverr a=%h w=%b: got %b, required %b", n, a, w, er, m_err); end
            if (rl !== m_prdata || el !== m_err) begin n_fail++; $display("FAIL rand_%0d_hold: got %h/%b, required %h/%b", n, rl, el, m_prdata, m_err); end
        end
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] rd, rl; logic er, el, ra; int wt;
        model_xfer(1'b0, 32'h100, '0);
        apb_xfer(1'b0, 20'h00100, '0, 1'b0, rd, er, wt, ra, rl, el);
        @(negedge PCLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 20'h00008; PWDATA = 32'hCAFE_F00D;
        @(negedge PCLK);
        PENABLE = 1'b1;
        PRESET = 1'b1;
        @(negedge PCLK);
        n_tests += 3;
        if (PREADY !== 1'b0)  begin n_fail++; $display("FAIL midrst_pready: got %b, required 0", PREADY); end
        if (PSLVERR !== 1'b0) begin n_fail++; $display("FAIL midrst_pslverr: got %b, required 0", PSLVERR); end
        if (PRDATA !== '0)    begin n_fail++; $display("FAIL midrst_prdata: got %h, required 0", PRDATA); end
        PRESET = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
        model_reset();
        model_xfer(1'b0, 32'h8, '0);
        apb_xfer(1'b0, 20'h00008, '0, 1'b0, rd, er, wt, ra, rl, el);
        n_tests++;
        if (rd !== 32'h0) begin n_fail++; $display("FAIL midrst_reg2: got %h, required 0", rd); end
        model_xfer(1'b0, 32'h104, '0);
        apb_xfer(1'b0, 20'h00104, '0, 1'b0, rd, er, wt, ra, rl, el);
        n_tests++;
        if (rd !== 32'h0) begin n_fail++; $display("FAIL midrst_wcnt: got %h, required 0", rd); end
    endtask

    initial begin
        test_reset();
        test_id_rcnt();
        test_write_read();
        test_wait_states();
        test_errors();
        test_extra_hold();
        test_idle_penable();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_slave_regbank.md
Name: apb_slave_regbank

Overview:
- APB slave peripheral that terminates transfers issued by the APB master on the shared APB bus.
- Provides NREGS general read/write registers, a read-only ID register, and read-only write/read transfer counters.
- Inserts a parameterised number of wait states and signals PSLVERR for illegal accesses.
- Serves as the default target for bus-level tests of the master.

Parameters:
- ADDR_W, 20, PADDR width.
- DATA_W, 32, PWDATA/PRDATA width.
- NREGS, 8, number of RW registers (1..64).
- WAIT_STATES, 0, ACCESS cycles with PREADY=0 before PREADY=1 (0..15).
- ID_VALUE, 32'h5A5B_0001, value returned by the ID register.

Ports:
- PCLK  in  1  bus clock; all logic on rising edge.
- PRESET  in  1  reset, synchronous, active-high.
- PSEL  in  1  slave select.
- PENABLE  in  1  access phase.
- PWRITE  in  1  1=write, 0=read.
- PADDR  in  ADDR_W  byte address.
- PWDATA  in  DATA_W  write data.
- PRDATA  out  DATA_W  read data, registered.
- PREADY  out  1  transfer completion, registered (state-derived).
- PSLVERR  out  1  error response, registered.

Behaviour:
- Reset:
  - Synchronous active-high on PCLK.
  - PRESET=1 at an edge forces state=IDLE, PREADY=0, PSLVERR=0, PRDATA=0, all REG[i]=0, WCNT=0, RCNT=0.
  - Reset mid-transfer aborts the transfer with no register or counter side effect.
- Address map (byte offsets, PADDR[1:0] must be 0):
  - REG[i] at 4*i, RW.
  - ID at 0x100, RO.
  - WCNT at 0x104, RO, 16-bit zero-extended.
  - RCNT at 0x108, RO, 16-bit zero-extended.
  - All other offsets are unmapped.
- FSM states: IDLE, ACCESS, DONE.
  - SETUP is detected in any state as PSEL=1 & PENABLE=0 at an edge. It loads wcnt=WAIT_STATES, latches PADDR/PWRITE/PWDATA, and moves to ACCESS.
  - ACCESS, PSEL=0: abort and go to IDLE (no side effects).
  - ACCESS, wcnt>0: decrement wcnt.
  - ACCESS, wcnt==0 and PSEL&PENABLE at the edge: complete the transfer and go to DONE.
  - DONE: ignore PSEL&PENABLE held high. Only a new SETUP starts the next transfer; PSEL=0 goes to IDLE.
  - IDLE: PENABLE=1 without a preceding SETUP is ignored.
- PREADY:
  - PREADY=1 exactly when state==ACCESS && wcnt==0; otherwise 0.
  - Transfer latency: SETUP edge + (WAIT_STATES+1) edges to the completing edge.
- Completion actions, taken at the completing edge only:
  - Legal write: REG[i]<=latched PWDATA; WCNT<=WCNT+1 (wraps 0xFFFF->0).
  - Legal read: PRDATA<=selected value; RCNT<=RCNT+1 (wraps). A read of RCNT returns the pre-increment value.
  - Error (unaligned, unmapped, or write to ID/WCNT/RCNT): PSLVERR<=1, no register/counter change, PRDATA<=0.
  - Legal completion sets PSLVERR<=0.
- Output hold:
  - PRDATA and PSLVERR hold their last completion values until the next completing edge, so the master may sample them one or two cycles after PREADY.
  - Writes do not alter PRDATA.
- Latched address/data are used for decode, so PADDR/PWDATA changes during ACCESS have no effect.

Decomposition:
- Package apb_slave_pkg holds:
  - state enum (IDLE, ACCESS, DONE);
  - offset constants ID_OFS=0x100, WCNT_OFS=0x104, RCNT_OFS=0x108;
  - default ID_VALUE;
  - decode-result enum (DEC_REG, DEC_ID, DEC_WCNT, DEC_RCNT, DEC_ERR).
- Sub-module apb_regbank_core holds the register array, counters and decode/readmux. The top holds the FSM, wait counter and output registers.

Test Plan:
- Reset, then read 0x00100 -> PRDATA=0x5A5B0001, PSLVERR=0; read 0x00108 -> 0x00000001 (the first read was counted).
- Write 0x00004 data 0xDEADBEEF, then read 0x00004 -> 0xDEADBEEF; read 0x00104 -> 0x00000001; other REGs still read 0.
- WAIT_STATES=2: write 0x00000 -> PREADY low for the first 2 ACCESS cycles, high on the 3rd; completion 3 edges after the SETUP edge.
- Write 0x00100 / 0x00006 / read 0x00200:
  - each -> PSLVERR=1 held until the next completion;
  - ID still 0x5A5B0001, WCNT unchanged, error read PRDATA=0;
  - a subsequent legal read clears PSLVERR.
- Master keeps PSEL=PENABLE=1 for one extra cycle after the completing edge -> exactly one write (WCNT increments by 1); read PRDATA stable through the extra cycle.
- PRESET=1 during ACCESS with wcnt>0 on a write to 0x00008 -> REG[2] stays 0, WCNT=0, all outputs 0 at the next edge.
